// File: rtl/da4_spi_writer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// da4_spi_writer
//
// Purpose: continuously streams a 12-bit DAC code to an AD5628-style quad DAC
// (PmodDA4). The code is written to all channels over SPI, and each frame
// writes and updates the DAC. Frames repeat forever, with a fixed SYNC-high gap
// between them.
//
// Optional feature (macro DA4_INIT_REF_EN): when defined, the first frame after
// every reset is a one-off INIT frame (0x08000001) that turns the internal
// reference on. When undefined, the first frame is already a WRITE frame.
//
// Parameters:
//   CLK_DIV  - SCLK half-period in clk cycles (1..255)
//   SYNC_GAP - clk cycles SYNC stays high between frames (1..255)
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   signal     in   12-bit unsigned DAC code, latched when SYNC falls
//   SYNC       out  frame select, active-low
//   DATA       out  serial data, MSB first, changes only as SCLK rises
//   SCLK       out  serial clock, idles high
//   frame_done out  one-cycle pulse on the first SYNC-high cycle after a frame
//   busy       out  high while SYNC is low
// -----------------------------------------------------------------------------
module da4_spi_writer #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned SYNC_GAP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] signal,
  output logic        SYNC,
  output logic        DATA,
  output logic        SCLK,
  output logic        frame_done,
  output logic        busy
);

`ifdef DA4_INIT_REF_EN
  typedef enum logic [1:0] {ST_RESET, ST_GAP, ST_INIT, ST_WRITE} state_t;
`else
  typedef enum logic [1:0] {ST_RESET, ST_GAP, ST_WRITE} state_t;
`endif

  localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(SYNC_GAP - 1);
  localparam logic [31:0] INIT_WORD = 32'h0800_0001;

  state_t      state_reg, state_next;
  logic [7:0]  div_reg, div_next;
  logic [7:0]  gap_reg, gap_next;
  logic [4:0]  bit_reg, bit_next;
  logic [31:0] shift_reg, shift_next;
  logic        sync_reg, sync_next;
  logic        sclk_reg, sclk_next;
  logic        done_reg, done_next;
`ifdef DA4_INIT_REF_EN
  logic        init_pending_reg, init_pending_next;
`endif

  // Write-and-update command to all channels; sampled only at frame start.
  logic [31:0] write_word;
  assign write_word = {4'h0, 4'b0011, 4'b1111, signal, 8'h00};

  // DATA is the MSB of the shift register, so it can only change when the
  // register shifts (SCLK rising) or is loaded/cleared at frame boundaries.
  assign SYNC       = sync_reg;
  assign SCLK       = sclk_reg;
  assign DATA       = shift_reg[31];
  assign frame_done = done_reg;
  assign busy       = ~sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_RESET;
      div_reg          <= '0;
      gap_reg          <= '0;
      bit_reg          <= '0;
      shift_reg        <= '0;
      sync_reg         <= 1'b1;
      sclk_reg         <= 1'b1;
      done_reg         <= 1'b0;
`ifdef DA4_INIT_REF_EN
      init_pending_reg <= 1'b1;
`endif
    end else begin
      state_reg        <= state_next;
      div_reg          <= div_next;
      gap_reg          <= gap_next;
      bit_reg          <= bit_next;
      shift_reg        <= shift_next;
      sync_reg         <= sync_next;
      sclk_reg         <= sclk_next;
      done_reg         <= done_next;
`ifdef DA4_INIT_REF_EN
      init_pending_reg <= init_pending_next;
`endif
    end
  end

  always_comb begin
    state_next        = state_reg;
    div_next          = div_reg;
    gap_next          = gap_reg;
    bit_next          = bit_reg;
    shift_next        = shift_reg;
    sync_next         = sync_reg;
    sclk_next         = sclk_reg;
    done_next         = 1'b0;
`ifdef DA4_INIT_REF_EN
    init_pending_next = init_pending_reg;
`endif

    case (state_reg)
      ST_RESET: begin
        state_next = ST_GAP;
        gap_next   = '0;
      end

      ST_GAP: begin
        if (gap_reg == GAP_LAST) begin
          // Frame start: SYNC falls and bit 31 appears on the same edge,
          // SCLK stays high for the first half-bit.
          sync_next = 1'b0;
          sclk_next = 1'b1;
          div_next  = '0;
          bit_next  = 5'd31;
`ifdef DA4_INIT_REF_EN
          if (init_pending_reg) begin
            state_next        = ST_INIT;
            shift_next        = INIT_WORD;
            init_pending_next = 1'b0;
          end else begin
            state_next = ST_WRITE;
            shift_next = write_word;
          end
`else
          state_next = ST_WRITE;
          shift_next = write_word;
`endif
        end else begin
          gap_next = gap_reg + 8'd1;
        end
      end

      // INIT and WRITE frames shift identically; only the loaded word differs.
      default: begin
        if (div_reg == DIV_LAST) begin
          div_next = '0;
          if (sclk_reg) begin
            sclk_next = 1'b0;
          end else if (bit_reg == 5'd0) begin
            // End of bit 0: frame over, go straight into the gap.
            sync_next  = 1'b1;
            sclk_next  = 1'b1;
            shift_next = '0;
            done_next  = 1'b1;
            state_next = ST_GAP;
            gap_next   = '0;
          end else begin
            bit_next   = bit_reg - 5'd1;
            sclk_next  = 1'b1;
            shift_next = {shift_reg[30:0], 1'b0};
          end
        end else begin
          div_next = div_reg + 8'd1;
        end
      end
    endcase
  end

endmodule
